// File: rtl/rank_8_seq.sv
`default_nettype none
// ============================================================================
// Module   : rank_8_seq
// Purpose  : Serial 8-value frame rank decoder: loads 8 values, computes each
//            one's stable ascending rank, then streams (idx, value, rank).
// Revision : 1.0 - initial release
// ============================================================================
module rank_8_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   out_idx,
    output logic [2:0]   out_rank,
    output logic         out_last,
    output logic         busy
);

    localparam logic [1:0] c_ST_LOAD = 2'd0;
    localparam logic [1:0] c_ST_RANK = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [W-1:0] data_q [8];
    logic [W-1:0] data_d [8];
    logic [2:0]   rank_q [8];
    logic [2:0]   rank_d [8];
    logic [2:0]   w_rank;

    // Element i outranks j when strictly larger, or equal and later in arrival.
    // At most 7 other elements can precede it, so 3 bits never overflow.
    always_comb begin
        w_rank = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if ((data_q[j] < data_q[cnt_q]) ||
                ((data_q[j] == data_q[cnt_q]) && (3'(j) < cnt_q))) begin
                w_rank = w_rank + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rank_d  = rank_q;
        case (state_q)
            c_ST_LOAD: begin
                if (in_valid) begin
                    data_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = c_ST_RANK;
                    end
                end
            end
            c_ST_RANK: begin
                rank_d[cnt_q] = w_rank;
                cnt_d         = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = c_ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = c_ST_LOAD;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_LOAD;
            cnt_q   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
                rank_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
                rank_q[i] <= rank_d[i];
            end
        end
    end

    // in_ready is masked by rst so it reads low for the whole reset pulse.
    assign in_ready  = (state_q == c_ST_LOAD) && !rst;
    assign out_valid = (state_q == c_ST_SEND);
    assign out_idx   = cnt_q;
    assign out_data  = data_q[cnt_q];
    assign out_rank  = rank_q[cnt_q];
    assign out_last  = (cnt_q == 3'd7);
    assign busy      = (state_q == c_ST_RANK) || (state_q == c_ST_SEND);

endmodule
`default_nettype wire

// File: tb/tb_rank_8_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rank_8_seq
// Purpose  : Scoreboard bench for rank_8_seq with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rank_8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic [2:0] out_rank;
    logic       out_last;
    logic       busy;

    rank_8_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_rank  (out_rank),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
        logic [2:0] rank;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   rdy_mode  = 1'b0;
    logic rdy_level = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // out_ready generator: level or toggling every cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = ~out_ready;
            else          out_ready = rdy_level;
        end
    end

    // Monitor: pops on each output handshake and checks backpressure hold.
    initial begin
        exp_t got;
        exp_t prev;
        exp_t e;
        bit   have_prev = 1'b0;
        forever begin
            @(negedge clk);
            got = {out_idx, out_data, out_rank, out_last};
            if (rst) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    total++;
                    if (!out_valid || got !== prev) begin
                        bad++;
                        $display("FAIL hold: got v=%0b %h expected v=1 %h", out_valid, got, prev);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got idx=%0d data=%0h rank=%0d expected none",
                                 out_idx, out_data, out_rank);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL triple: got idx=%0d data=%0h rank=%0d last=%0b expected idx=%0d data=%0h rank=%0d last=%0b",
                                     got.idx, got.data, got.rank, got.last, e.idx, e.data, e.rank, e.last);
                        end
                    end
                end
                have_prev = out_valid && !out_ready;
                prev      = got;
            end
        end
    end

    task automatic run_frame(input logic [7:0] v[8], input logic [2:0] r[8],
                             input bit push, input int gap, input bit junk, input bit lat);
        int  n;
        bit  early;
        for (int i = 0; i < 8; i++) begin
            if (push) sb.push_back({3'(i), v[i], r[i], (i == 7)});
            in_valid = 1'b1;
            in_data  = v[i];
            n = 0;
            while (!in_ready && n < 200) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        if (lat) begin
            early = out_valid;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (k == 1) chk("busy_rank", 32'(busy), 32'd1);
                if (k < 8) early = early | out_valid;
            end
            chk("latency_early", 32'(early), 32'd0);
            chk("latency_first", 32'(out_valid), 32'd1);
        end
        if (junk) begin
            n = 0;
            do begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
                n++;
            end while (busy && n < 200);
            in_valid = 1'b0;
            chk("junk_end_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] v[8];
        logic [2:0] r[8];
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of SEND: nothing from this frame may come out.
        rdy_level = 1'b0;
        v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        r = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        run_frame(v, r, 1'b0, 0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("send_reached", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midsend_out_valid", 32'(out_valid), 32'd0);
        chk("midsend_busy", 32'(busy), 32'd0);
        chk("midsend_in_ready", 32'(in_ready), 32'd0);
        chk("midsend_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        rdy_level = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Ascending with latency check.
        v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        r = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b1);
        drain();

        // Descending, then ties at 0x55, 0x00, 0xFF back to back.
        v = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        r = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b0);
        r = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        v = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b0);
        v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b0);
        v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b0);
        drain();

        // Mixed values with toggling out_ready.
        rdy_mode = 1'b1;
        v = '{8'd5, 8'd200, 8'd5, 8'd0, 8'd255, 8'd17, 8'd200, 8'd3};
        r = '{3'd2, 3'd5, 3'd3, 3'd0, 3'd7, 3'd4, 3'd6, 3'd1};
        run_frame(v, r, 1'b1, 0, 1'b0, 1'b0);
        drain();

        // Input gaps plus junk in_valid during RANK/SEND, then a clean frame.
        v = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
        r = '{3'd3, 3'd0, 3'd4, 3'd1, 3'd5, 3'd7, 3'd2, 3'd6};
        run_frame(v, r, 1'b1, 2, 1'b1, 1'b0);
        rdy_mode  = 1'b0;
        rdy_level = 1'b1;
        v = '{8'd5, 8'd200, 8'd5, 8'd0, 8'd255, 8'd17, 8'd200, 8'd3};
        r = '{3'd2, 3'd5, 3'd3, 3'd0, 3'd7, 3'd4, 3'd6, 3'd1};
        run_frame(v, r, 1'b1, 1, 1'b1, 1'b0);
        drain();
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
